stash_ctrl: RTL and testbench
=============================

# stash_ctrl

Lap-memory controller for the stopwatch datapath. It sits between the debounced front-panel button pulses and the lap stash (8-bit sample buffer, DEPTH entries, circular write and read pointers that each advance by one per strobe). It captures the running time on a lap press, tracks how many laps are stored, and sequences the stash read pointer in review mode so that only valid entries are shown. It also drives the display live/review select.

## Interface
- DEPTH, 5: stash entries. Must equal the stash DEPTH. CW = $clog2(DEPTH+1).
- TIMEOUT_CYCLES, 100_000_000: idle review cycles before auto-return to live. Used only when the timeout feature is compiled in.
- clk  in  1  system clock.
- reset  in  1  synchronous, active-low reset.
- btn_lap  in  1  one-cycle pulse; capture a lap.
- btn_review  in  1  one-cycle pulse; toggle LIVE/REVIEW.
- btn_next  in  1  one-cycle pulse; show next stored lap (REVIEW only).
- btn_clear  in  1  one-cycle pulse; erase all laps.
- time_in  in  8  current stopwatch reading.
- stash_sample  out  8  data to the stash sample_in.
- stash_valid  out  1  write strobe to the stash sample_in_valid.
- stash_next  out  1  read-advance strobe to the stash next_sample.
- stash_clear  out  1  active-high clear to the stash reset.
- review  out  1  display select: 1 = show stash output.
- lap_count  out  CW  number of stored laps, saturates at DEPTH.
- busy  out  1  high while in SKIP.

## Operation
- The block keeps shadow copies of the stash pointers: wr_idx and rd_idx, both mod DEPTH. It also keeps cnt = lap_count.
- Event priority within a cycle: clear > review toggle > next. Lap capture is independent of the other events and is always honoured, except on clear.
- **Clear:** stash_clear=1 for one cycle. wr_idx, rd_idx and cnt go to 0. State goes to LIVE. A btn_lap in the same cycle is dropped.
- **Lap:** stash_sample is latched from time_in. stash_valid=1 for one cycle. wr_idx advances with wrap. cnt increments, saturating at DEPTH. Once full, the oldest lap is overwritten.
- **FSM states:** LIVE, REVIEW, SKIP. All outputs are registered.
  - LIVE: review=0. btn_review moves to REVIEW. btn_next is ignored.
  - REVIEW: review=1. btn_review moves to LIVE. btn_next does the following:
    - cnt==0: ignored.
    - cnt==DEPTH, or rd_idx+1 < cnt: one stash_next pulse; rd_idx advances with wrap.
    - otherwise (rd_idx == cnt-1 with cnt < DEPTH): load skip = DEPTH-cnt+1 and enter SKIP.
  - SKIP: busy=1, review=1. Issue one stash_next per cycle, decrementing skip. When the last pulse is issued, rd_idx=0 and the state returns to REVIEW. btn_next and btn_review are ignored in SKIP; btn_clear and btn_lap are honoured.
- **Reset** (reset low at a clk edge), applied mid-operation as well:
  - state LIVE; wr_idx, rd_idx and cnt = 0.
  - stash_clear=1; stash_valid, stash_next, review and busy = 0; stash_sample=0; lap_count=0.
  - stash_clear stays 1 while reset is held and drops at the first edge after release.

## Timing
- Every button is sampled at edge k. The response is visible after edge k, during cycle k+1. No combinational path from inputs to outputs.
- Lap: stash_valid is high in cycle k+1 with stash_sample = time_in as sampled at edge k. lap_count updates in the same cycle.
- Next with a single pulse: stash_next is high in cycle k+1. The new entry shows on the stash output in cycle k+2.
- SKIP: stash_next is high for exactly skip consecutive cycles starting at k+1. busy covers the same cycles. The block accepts btn_next again in the cycle after busy falls.
- Clear: stash_clear is high in cycle k+1 only. lap_count=0 in cycle k+1.
- Strobes never stay high longer than one cycle, except stash_next during SKIP and stash_clear during reset.

## Configuration
- STASH_CTRL_TIMEOUT_EN:
  - Defined: an idle counter runs in REVIEW only and is cleared by btn_next or btn_review. When it reaches TIMEOUT_CYCLES-1, the FSM returns to LIVE on the next edge. The counter is held at 0 in LIVE and SKIP.
  - Undefined: there is no counter, and REVIEW exits only on btn_review, btn_clear or reset.

## Test plan
- Reset held for 3 cycles, then released → stash_clear=1 throughout reset and 0 from the first cycle after release; all other outputs are 0.
- Three laps with time_in=0x11, 0x22, 0x33 → three 1-cycle stash_valid pulses carrying those values; lap_count=3.
- After the three laps, btn_review then btn_next ×3 → two single stash_next pulses, then SKIP with 3 consecutive stash_next (DEPTH-cnt+1=3) and busy high for 3 cycles; rd_idx=0 (showing 0x11).
- Six laps (DEPTH=5) → lap_count saturates at 5; in review each btn_next gives exactly one stash_next, wrapping 4→0.
- btn_clear and btn_lap in the same cycle during REVIEW → stash_clear pulse, no stash_valid, lap_count=0, review=0.
- With STASH_CTRL_TIMEOUT_EN and TIMEOUT_CYCLES=8: enter REVIEW with no further presses → review falls 8 cycles later; a btn_next at cycle 5 restarts the count.

Source files
------------

// File: rtl/stash_ctrl.sv
// Lap-memory controller: captures laps into the circular stash, tracks the lap count and
// steps the stash read pointer in review mode. Optional review idle timeout: STASH_CTRL_TIMEOUT_EN.
module stash_ctrl #(
    parameter int DEPTH          = 5,
    parameter int TIMEOUT_CYCLES = 100_000_000,
    localparam int CW            = $clog2(DEPTH + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          btn_lap,
    input  logic          btn_review,
    input  logic          btn_next,
    input  logic          btn_clear,
    input  logic [7:0]    time_in,
    output logic [7:0]    stash_sample,
    output logic          stash_valid,
    output logic          stash_next,
    output logic          stash_clear,
    output logic          review,
    output logic [CW-1:0] lap_count,
    output logic          busy
);
    localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    typedef enum logic [1:0] {ST_LIVE, ST_REVIEW, ST_SKIP} state_t;

    state_t        r_state;
    logic [IW-1:0] r_wr_idx;
    logic [IW-1:0] r_rd_idx;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] r_skip;
    logic [7:0]    r_sample;
    logic          r_valid;
    logic          r_next;
    logic          r_clear;
    logic          r_review;
    logic          r_busy;

    logic [CW-1:0] w_rd_inc;
    logic [IW-1:0] w_rd_wrap;
    logic [IW-1:0] w_wr_wrap;
    logic          w_timeout;

    assign w_rd_inc  = CW'(r_rd_idx) + CW'(1);
    assign w_rd_wrap = (r_rd_idx == IW'(DEPTH - 1)) ? '0 : r_rd_idx + IW'(1);
    assign w_wr_wrap = (r_wr_idx == IW'(DEPTH - 1)) ? '0 : r_wr_idx + IW'(1);

`ifdef STASH_CTRL_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
    logic [TW-1:0] r_idle;

    assign w_timeout = (r_idle == TW'(TIMEOUT_CYCLES - 1));

    // Counts only untouched REVIEW cycles; any other state or a review/next press restarts it.
    always_ff @(posedge clk) begin
        if (!reset || btn_clear || r_state != ST_REVIEW || btn_next || btn_review || w_timeout) begin
            r_idle <= '0;
        end else begin
            r_idle <= r_idle + TW'(1);
        end
    end
`else
    localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= ST_LIVE;
            r_wr_idx <= '0;
            r_rd_idx <= '0;
            r_cnt    <= '0;
            r_skip   <= '0;
            r_sample <= '0;
            r_valid  <= 1'b0;
            r_next   <= 1'b0;
            r_clear  <= 1'b1;
            r_review <= 1'b0;
            r_busy   <= 1'b0;
        end else begin
            r_valid <= 1'b0;
            r_next  <= 1'b0;
            r_clear <= 1'b0;
            if (btn_clear) begin
                r_clear  <= 1'b1;
                r_wr_idx <= '0;
                r_rd_idx <= '0;
                r_cnt    <= '0;
                r_skip   <= '0;
                r_state  <= ST_LIVE;
                r_review <= 1'b0;
                r_busy   <= 1'b0;
            end else begin
                if (btn_lap) begin
                    r_sample <= time_in;
                    r_valid  <= 1'b1;
                    r_wr_idx <= w_wr_wrap;
                    if (r_cnt != CW'(DEPTH)) begin
                        r_cnt <= r_cnt + CW'(1);
                    end
                end
                case (r_state)
                    ST_LIVE: begin
                        if (btn_review) begin
                            r_state  <= ST_REVIEW;
                            r_review <= 1'b1;
                        end
                    end
                    ST_REVIEW: begin
                        if (btn_review) begin
                            r_state  <= ST_LIVE;
                            r_review <= 1'b0;
                        end else if (btn_next) begin
                            if (r_cnt != '0) begin
                                r_next <= 1'b1;
                                if (r_cnt == CW'(DEPTH) || w_rd_inc < r_cnt) begin
                                    r_rd_idx <= w_rd_wrap;
                                end else begin
                                    // Past the newest lap of a partly filled stash: spin the
                                    // pointer round to slot 0; first pulse goes out now.
                                    r_busy  <= 1'b1;
                                    r_skip  <= CW'(DEPTH) - r_cnt;
                                    r_state <= ST_SKIP;
                                end
                            end
                        end else if (w_timeout) begin
                            r_state  <= ST_LIVE;
                            r_review <= 1'b0;
                        end
                    end
                    ST_SKIP: begin
                        if (r_skip != '0) begin
                            r_next <= 1'b1;
                            r_skip <= r_skip - CW'(1);
                            if (r_skip == CW'(1)) begin
                                r_rd_idx <= '0;
                            end
                        end else begin
                            r_busy  <= 1'b0;
                            r_state <= ST_REVIEW;
                        end
                    end
                    default: begin
                        r_state <= ST_LIVE;
                    end
                endcase
            end
        end
    end

    assign stash_sample = r_sample;
    assign stash_valid  = r_valid;
    assign stash_next   = r_next;
    assign stash_clear  = r_clear;
    assign review       = r_review;
    assign lap_count    = r_cnt;
    assign busy         = r_busy;
endmodule

// File: tb/tb_stash_ctrl.sv
// Directed bench for stash_ctrl: a lap-list model predicts every output each cycle, and a
// small stash model driven by the DUT strobes shows which lap would be on the display.
module tb_stash_ctrl;
    localparam int DEPTH = 5;
    localparam int TO    = 8;
    localparam int CW    = $clog2(DEPTH + 1);

    logic          clk = 1'b0;
    logic          reset;
    logic          btn_lap;
    logic          btn_review;
    logic          btn_next;
    logic          btn_clear;
    logic [7:0]    time_in;
    logic [7:0]    stash_sample;
    logic          stash_valid;
    logic          stash_next;
    logic          stash_clear;
    logic          review;
    logic [CW-1:0] lap_count;
    logic          busy;

    always #5 clk = ~clk;

    stash_ctrl #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TO)) dut (
        .clk(clk), .reset(reset), .btn_lap(btn_lap), .btn_review(btn_review),
        .btn_next(btn_next), .btn_clear(btn_clear), .time_in(time_in),
        .stash_sample(stash_sample), .stash_valid(stash_valid), .stash_next(stash_next),
        .stash_clear(stash_clear), .review(review), .lap_count(lap_count), .busy(busy)
    );

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 1'b0;

    // Model: mode 0 = live, 1 = review, 2 = skipping; view = lap slot being shown.
    int m_mode = 0, m_cnt = 0, m_view = 0, m_pend = 0, m_idle = 0;
    int e_valid = 0, e_next = 0, e_clear = 1, e_review = 0, e_busy = 0, e_count = 0, e_sample = 0;

    logic [7:0] s_mem [DEPTH];
    int s_wp = 0, s_rp = 0;
    int n_next_seen = 0, n_busy_seen = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_step(input bit rst_n, input bit lap, input bit rev, input bit nxt,
                              input bit clr, input logic [7:0] tin);
        int old_cnt  = m_cnt;
        int old_mode = m_mode;
        bit tmo      = 1'b0;
`ifdef STASH_CTRL_TIMEOUT_EN
        tmo = (m_idle == TO - 1);
`endif
        e_valid = 0;
        e_next  = 0;
        e_clear = 0;
        if (!rst_n) begin
            m_mode = 0; m_cnt = 0; m_view = 0; m_pend = 0;
            e_clear = 1; e_sample = 0;
        end else if (clr) begin
            m_mode = 0; m_cnt = 0; m_view = 0; m_pend = 0;
            e_clear = 1;
        end else begin
            if (lap) begin
                e_valid  = 1;
                e_sample = int'(tin);
                if (m_cnt < DEPTH) m_cnt++;
            end
            case (old_mode)
                0: if (rev) m_mode = 1;
                1: begin
                    if (rev) m_mode = 0;
                    else if (nxt) begin
                        if (old_cnt > 0) begin
                            e_next = 1;
                            if (old_cnt == DEPTH || m_view + 1 < old_cnt) begin
                                m_view = (m_view + 1) % DEPTH;
                            end else begin
                                m_mode = 2;
                                m_pend = DEPTH - old_cnt;  // pulses still owed after this one
                            end
                        end
                    end else if (tmo) m_mode = 0;
                end
                default: begin
                    if (m_pend > 0) begin
                        e_next = 1;
                        m_pend--;
                    end else begin
                        m_mode = 1;
                        m_view = 0;
                    end
                end
            endcase
        end
        if (rst_n && !clr && old_mode == 1 && !rev && !nxt && !tmo) m_idle++;
        else m_idle = 0;
        e_review = (m_mode != 0) ? 1 : 0;
        e_busy   = (m_mode == 2) ? 1 : 0;
        e_count  = m_cnt;
    endtask

    task automatic cyc(input bit rst_n, input bit lap, input bit rev, input bit nxt,
                       input bit clr, input logic [7:0] tin);
        reset = rst_n; btn_lap = lap; btn_review = rev; btn_next = nxt;
        btn_clear = clr; time_in = tin;
        @(posedge clk);
        model_step(rst_n, lap, rev, nxt, clr, tin);
        #1;
        chk_en = 1'b1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
    endtask
    task automatic do_lap(input logic [7:0] v);   cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, v);     endtask
    task automatic do_rev();                      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00); endtask
    task automatic do_next();                     cyc(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00); endtask

    // Stash stand-in: reacts to the strobes the DUT issued in the cycle just ending.
    initial forever begin
        @(posedge clk);
        if (stash_clear === 1'b1) begin
            s_wp = 0;
            s_rp = 0;
            for (int i = 0; i < DEPTH; i++) s_mem[i] = 8'h00;
        end else begin
            if (stash_valid === 1'b1) begin
                s_mem[s_wp] = stash_sample;
                s_wp = (s_wp + 1) % DEPTH;
            end
            if (stash_next === 1'b1) s_rp = (s_rp + 1) % DEPTH;
        end
    end

    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            check("stash_valid",  int'(stash_valid),  e_valid);
            check("stash_sample", int'(stash_sample), e_sample);
            check("stash_next",   int'(stash_next),   e_next);
            check("stash_clear",  int'(stash_clear),  e_clear);
            check("review",       int'(review),       e_review);
            check("busy",         int'(busy),         e_busy);
            check("lap_count",    int'(lap_count),    e_count);
            if (stash_next === 1'b1) n_next_seen++;
            if (busy === 1'b1) n_busy_seen++;
        end
    end

    initial begin
        int n0, b0;
        for (int i = 0; i < 3; i++) cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        check("reset_clear", int'(stash_clear), 1);
        check("reset_review", int'(review), 0);
        check("reset_count", int'(lap_count), 0);
        idle(1);
        check("release_clear", int'(stash_clear), 0);

        do_lap(8'h11);
        check("lap1_valid", int'(stash_valid), 1);
        check("lap1_sample", int'(stash_sample), 8'h11);
        do_lap(8'h22);
        do_lap(8'h33);
        check("lap3_sample", int'(stash_sample), 8'h33);
        idle(1);
        check("lap_valid_drop", int'(stash_valid), 0);
        check("count_3", int'(lap_count), 3);

        do_next();                      // ignored in LIVE
        do_rev();
        check("review_on", int'(review), 1);
        do_next(); idle(1);
        check("show_22", int'(s_mem[s_rp]), 8'h22);
        do_next(); idle(1);
        check("show_33", int'(s_mem[s_rp]), 8'h33);
        n0 = n_next_seen; b0 = n_busy_seen;
        do_next();                      // enters SKIP
        check("skip_busy_now", int'(busy), 1);
        do_next();                      // ignored while busy
        idle(2);
        check("skip_pulses", n_next_seen - n0, 3);
        check("skip_busy_cycles", n_busy_seen - b0, 3);
        check("skip_show_11", int'(s_mem[s_rp]), 8'h11);
        check("skip_done_busy", int'(busy), 0);
        do_next(); idle(1);
        check("after_skip_22", int'(s_mem[s_rp]), 8'h22);

        cyc(1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'h99);
        check("clr_pulse", int'(stash_clear), 1);
        check("clr_no_valid", int'(stash_valid), 0);
        check("clr_count", int'(lap_count), 0);
        check("clr_review", int'(review), 0);
        idle(1);
        check("clr_drop", int'(stash_clear), 0);

        for (int i = 0; i < 6; i++) do_lap(8'(8'h41 + i));
        idle(1);
        check("count_sat", int'(lap_count), 5);
        do_rev();
        n0 = n_next_seen; b0 = n_busy_seen;
        for (int i = 0; i < 5; i++) begin
            do_next(); idle(1);
            if (i == 0) check("full_show_42", int'(s_mem[s_rp]), 8'h42);
        end
        check("full_pulses", n_next_seen - n0, 5);
        check("full_no_busy", n_busy_seen - b0, 0);
        check("full_wrap_46", int'(s_mem[s_rp]), 8'h46);

        cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00);
        cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h55);
        check("midrst_clear", int'(stash_clear), 1);
        check("midrst_review", int'(review), 0);
        check("midrst_count", int'(lap_count), 0);
        idle(1);
        check("midrst_release", int'(stash_clear), 0);

`ifdef STASH_CTRL_TIMEOUT_EN
        do_rev();
        idle(4);
        do_next();                      // restarts the idle count
        idle(7);
        check("tmo_still_review", int'(review), 1);
        idle(1);
        check("tmo_back_live", int'(review), 0);
`endif
        idle(2);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
